// File: rtl/pm_loader_if.sv
// Program-memory write port driven by pm_loader: address, data, write strobe
// and the load-complete flag seen by the machine core.
interface pm_loader_if #(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 4
) ();
  logic [ADDR_W-1:0] pm_address;
  logic [OP_W-1:0]   pm_data;
  logic              pm_wren;
  logic              pm_input_done;

  modport master (
    output pm_address,
    output pm_data,
    output pm_wren,
    output pm_input_done
  );

  modport slave (
    input pm_address,
    input pm_data,
    input pm_wren,
    input pm_input_done
  );
endinterface

// File: rtl/pm_loader.sv
// Program-memory loader for the BF machine: debounced switch/button capture into PM from 0.
// Optional bracket-balance checking is enabled by defining PM_LOADER_BRACKET_CHECK_EN.
//
// state   | meaning
// S_LOAD  | waiting for an Enter or Finish edge
// S_WRITE | one-cycle write of a captured opcode
// S_TERM  | one-cycle write of the END terminator
// S_DONE  | program loaded, inputs ignored until reset
// S_ERROR | bracket imbalance at terminate, inputs ignored until reset
module pm_loader #(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   op_switches_i,
  input  logic              enter_i,
  input  logic              finish_i,
  pm_loader_if.master       pm,
  output logic              full_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] length_o
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_WRITE = 3'd1,
    S_TERM  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [OP_W-1:0]   OP_END   = '0;
  localparam logic [OP_W-1:0]   OP_MAX   = OP_W'(8);
  localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};
`ifdef PM_LOADER_BRACKET_CHECK_EN
  localparam logic [OP_W-1:0]   OP_OPEN  = OP_W'(7);
  localparam logic [OP_W-1:0]   OP_CLOSE = OP_W'(8);
`endif

  state_t            state_q, state_d;
  logic [2:0]        enter_s_q, finish_s_q;
  logic [OP_W-1:0]   op_s1_q, op_s2_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [OP_W-1:0]   data_q, data_d;
  logic              wren_q, wren_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
`ifdef PM_LOADER_BRACKET_CHECK_EN
  logic [ADDR_W-1:0] depth_q, depth_d;
`endif

  logic enter_edge, finish_edge;

  assign enter_edge  = enter_s_q[1] & ~enter_s_q[2];
  assign finish_edge = finish_s_q[1] & ~finish_s_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_s_q  <= '0;
      finish_s_q <= '0;
      op_s1_q    <= '0;
      op_s2_q    <= '0;
    end else begin
      enter_s_q  <= {enter_s_q[1:0], enter_i};
      finish_s_q <= {finish_s_q[1:0], finish_i};
      op_s1_q    <= op_switches_i;
      op_s2_q    <= op_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      addr_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
`ifdef PM_LOADER_BRACKET_CHECK_EN
      depth_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
      err_q   <= err_d;
      full_q  <= full_d;
`ifdef PM_LOADER_BRACKET_CHECK_EN
      depth_q <= depth_d;
`endif
    end
  end

  // Outputs are all registered; write strobe is raised on entry to WRITE/TERM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    full_d  = full_q;
`ifdef PM_LOADER_BRACKET_CHECK_EN
    depth_d = depth_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (finish_edge) begin
          state_d = S_TERM;
          wren_d  = 1'b1;
          data_d  = OP_END;
        end else if (enter_edge && !full_q) begin
          if (op_s2_q == OP_END) begin
            state_d = S_TERM;
            wren_d  = 1'b1;
            data_d  = OP_END;
          end else if (op_s2_q > OP_MAX) begin
            err_d = 1'b1;
`ifdef PM_LOADER_BRACKET_CHECK_EN
          end else if (op_s2_q == OP_CLOSE && depth_q == '0) begin
            err_d = 1'b1;
`endif
          end else begin
            state_d = S_WRITE;
            wren_d  = 1'b1;
            data_d  = op_s2_q;
          end
        end
      end
      S_WRITE: begin
        state_d = S_LOAD;
        addr_d  = addr_q + ADDR_W'(1);
        len_d   = len_q + ADDR_W'(1);
        full_d  = (addr_q == ADDR_TOP - ADDR_W'(1));
`ifdef PM_LOADER_BRACKET_CHECK_EN
        if (data_q == OP_OPEN)
          depth_d = depth_q + ADDR_W'(1);
        else if (data_q == OP_CLOSE)
          depth_d = depth_q - ADDR_W'(1);
`endif
      end
      S_TERM: begin
`ifdef PM_LOADER_BRACKET_CHECK_EN
        if (depth_q != '0) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
`else
        state_d = S_DONE;
        done_d  = 1'b1;
`endif
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_LOAD;
    endcase
  end

  assign pm.pm_address    = addr_q;
  assign pm.pm_data       = data_q;
  assign pm.pm_wren       = wren_q;
  assign pm.pm_input_done = done_q;
  assign full_o           = full_q;
  assign error_o          = err_q;
  assign length_o         = len_q;

endmodule

// File: tb/tb_pm_loader.sv
// Self-checking bench for pm_loader: button presses checked against a press-level model
// of the expected program-memory writes and status flags.
module tb_pm_loader;
  localparam int ADDR_W = 8;
  localparam int OP_W   = 4;

  logic              clk;
  logic              rst_n;
  logic [OP_W-1:0]   op_sw;
  logic              enter;
  logic              finish;
  logic              full;
  logic              error;
  logic [ADDR_W-1:0] length;

  int n_cmp;
  int n_bad;

  // press-level model of the loader
  int         m_addr;
  int         m_len;
  bit         m_err;
  bit         m_done;
  bit         m_halt;
  int         m_depth;

  pm_loader_if #(.ADDR_W(ADDR_W), .OP_W(OP_W)) pm_if ();

  pm_loader #(.ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_switches_i(op_sw),
    .enter_i      (enter),
    .finish_i     (finish),
    .pm           (pm_if),
    .full_o       (full),
    .error_o      (error),
    .length_o     (length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_addr  = 0;
    m_len   = 0;
    m_err   = 0;
    m_done  = 0;
    m_halt  = 0;
    m_depth = 0;
  endtask

  task automatic check_idle(input string tag);
    n_cmp++;
    if (pm_if.pm_address !== '0 || pm_if.pm_data !== '0 || pm_if.pm_wren !== 1'b0 ||
        pm_if.pm_input_done !== 1'b0 || full !== 1'b0 || error !== 1'b0 || length !== '0) begin
      n_bad++;
      $display("FAIL %s: addr=%0d data=%0d wren=%b done=%b full=%b err=%b len=%0d, want all zero",
               tag, pm_if.pm_address, pm_if.pm_data, pm_if.pm_wren, pm_if.pm_input_done,
               full, error, length);
    end
  endtask

  task automatic apply_reset();
    enter  = 1'b0;
    finish = 1'b0;
    op_sw  = '0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_idle("reset_async");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // One button press; the model decides what, if anything, must be written.
  task automatic press(input string tag, input bit do_enter, input bit do_finish,
                       input logic [OP_W-1:0] op, input int hold);
    bit              exp_w;
    bit              term;
    int              exp_a;
    logic [OP_W-1:0] exp_d;
    int              seen;
    int              seen_at;
    int              n;
    logic [ADDR_W-1:0] got_a;
    logic [OP_W-1:0]   got_d;
    exp_w = 0;
    term  = 0;
    exp_a = 0;
    exp_d = '0;
    if (!(m_done || m_halt)) begin
      if (do_finish) begin
        exp_w = 1; exp_a = m_addr; exp_d = '0; term = 1;
      end else if (do_enter && m_addr != (1 << ADDR_W) - 1) begin
        if (op == 0) begin
          exp_w = 1; exp_a = m_addr; exp_d = '0; term = 1;
        end else if (op > 8) begin
          m_err = 1;
`ifdef PM_LOADER_BRACKET_CHECK_EN
        end else if (op == 8 && m_depth == 0) begin
          m_err = 1;
`endif
        end else begin
          exp_w = 1; exp_a = m_addr; exp_d = op;
          m_addr++;
          m_len++;
          if (op == 7) m_depth++;
          if (op == 8) m_depth--;
        end
      end
      if (term) begin
`ifdef PM_LOADER_BRACKET_CHECK_EN
        if (m_depth != 0) begin
          m_halt = 1;
          m_err  = 1;
        end else begin
          m_done = 1;
        end
`else
        m_done = 1;
`endif
      end
    end

    op_sw = op;
    repeat (3) @(posedge clk);
    #1;
    enter  = do_enter;
    finish = do_finish;
    n = (hold > 8) ? hold : 8;
    seen = 0;
    seen_at = 0;
    got_a = '0;
    got_d = '0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (pm_if.pm_wren === 1'b1) begin
        seen++;
        if (seen == 1) begin
          seen_at = i;
          got_a   = pm_if.pm_address;
          got_d   = pm_if.pm_data;
        end
      end
      if (term && i == 3) begin
        n_cmp++;
        if (pm_if.pm_input_done !== 1'b0) begin
          n_bad++;
          $display("FAIL %s done_early: got %b, want 0 in write cycle", tag, pm_if.pm_input_done);
        end
      end
      if (term && i == 4) begin
        n_cmp++;
        if (pm_if.pm_input_done !== m_done) begin
          n_bad++;
          $display("FAIL %s done_rise: got %b, want %b", tag, pm_if.pm_input_done, m_done);
        end
      end
      if (i == hold) begin
        enter  = 1'b0;
        finish = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;

    n_cmp++;
    if (seen != (exp_w ? 1 : 0)) begin
      n_bad++;
      $display("FAIL %s wren_count: got %0d pulses, want %0d", tag, seen, exp_w ? 1 : 0);
    end
    if (exp_w) begin
      n_cmp++;
      if (seen_at != 3 || got_a !== ADDR_W'(exp_a) || got_d !== exp_d) begin
        n_bad++;
        $display("FAIL %s write: got addr=%0d data=%0d at cycle %0d, want addr=%0d data=%0d at cycle 3",
                 tag, got_a, got_d, seen_at, exp_a, exp_d);
      end
    end
    n_cmp++;
    if (length !== ADDR_W'(m_len) || full !== (m_addr == (1 << ADDR_W) - 1) ||
        error !== m_err || pm_if.pm_input_done !== m_done) begin
      n_bad++;
      $display("FAIL %s status: got len=%0d full=%b err=%b done=%b, want len=%0d full=%b err=%b done=%b",
               tag, length, full, error, pm_if.pm_input_done,
               m_len, (m_addr == (1 << ADDR_W) - 1), m_err, m_done);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_idle("reset_release");
  endtask

  task automatic test_basic();
    apply_reset();
    press("basic_op0", 1, 0, 4'd3, 2);
    press("basic_op1", 1, 0, 4'd3, 1);
    press("basic_op2", 1, 0, 4'd5, 4);
    press("basic_fin", 0, 1, 4'd6, 3);
    press("basic_after_done", 1, 0, 4'd3, 2);
    press("basic_fin_after_done", 0, 1, 4'd0, 2);
  endtask

  task automatic test_hold();
    apply_reset();
    press("hold50", 1, 0, 4'd1, 50);
  endtask

  task automatic test_invalid();
    apply_reset();
    press("invalid12", 1, 0, 4'd12, 2);
    press("after_invalid", 1, 0, 4'd3, 2);
    press("invalid15", 1, 0, 4'd15, 1);
    press("enter_zero", 1, 0, 4'd0, 2);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    press("simul_op0", 1, 0, 4'd7, 1);
    press("simul_op1", 1, 0, 4'd2, 1);
    press("simul_both", 1, 1, 4'd4, 2);
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < (1 << ADDR_W) - 1; i++)
      press("fill", 1, 0, 4'd3, 1);
    press("full_extra", 1, 0, 4'd4, 2);
    press("full_zero", 1, 0, 4'd0, 2);
    press("full_fin", 0, 1, 4'd0, 2);
  endtask

`ifdef PM_LOADER_BRACKET_CHECK_EN
  task automatic test_brackets();
    apply_reset();
    press("close_first", 1, 0, 4'd8, 2);
    apply_reset();
    press("br_open0", 1, 0, 4'd7, 1);
    press("br_open1", 1, 0, 4'd7, 1);
    press("br_close", 1, 0, 4'd8, 1);
    press("br_fin", 0, 1, 4'd0, 2);
  endtask
`endif

  task automatic test_random();
    logic [OP_W-1:0] op;
    int              kind;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) op = OP_W'($urandom_range(1, 8));
      else                           op = OP_W'($urandom_range(0, 15));
      kind = $urandom_range(0, 39);
      if (kind == 0)      press("rand_fin", 0, 1, op, $urandom_range(1, 12));
      else if (kind == 1) press("rand_both", 1, 1, op, $urandom_range(1, 12));
      else                press("rand_enter", 1, 0, op, $urandom_range(1, 12));
    end
    press("rand_end", 0, 1, '0, 2);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    press("mid_pre", 1, 0, 4'd3, 1);
    op_sw = 4'd4;
    repeat (3) @(posedge clk);
    #1 enter = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (pm_if.pm_wren !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_wren: got %b, want 1 before reset", pm_if.pm_wren);
    end
    #2 rst_n = 1'b0;
    #1 check_idle("mid_reset");
    enter = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    press("mid_after", 1, 0, 4'd3, 2);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b1;
    enter  = 1'b0;
    finish = 1'b0;
    op_sw  = '0;
    model_clear();
    test_reset();
    test_basic();
    test_hold();
    test_invalid();
    test_simultaneous();
    test_full();
`ifdef PM_LOADER_BRACKET_CHECK_EN
    test_brackets();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pm_loader.md
# pm_loader

Program-memory writer for the BF machine: captures 4-bit opcodes from board switches on debounced Enter presses and writes them sequentially into program memory from address 0, ending with an END opcode. It drives the memory write port while the machine core sits in reset, then raises PMInputDone, the core's load-complete input. It is the write-side counterpart of the core's program-counter read path.

## Interface
- ADDR_W, 8: program memory address width; capacity 2^ADDR_W words
- OP_W, 4: opcode width, matching program memory data width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- OpSwitches  in  OP_W  opcode to store, asynchronous board switches
- Enter  in  1  store button, asynchronous level, active-high
- Finish  in  1  end-of-program button, asynchronous level, active-high
- PMAddress  out  ADDR_W  write address to program memory
- PMData  out  OP_W  write data to program memory
- PMWren  out  1  write enable, one-cycle pulse per write
- PMInputDone  out  1  program loaded; held high until reset
- Full  out  1  only the terminator slot remains
- Error  out  1  sticky error flag
- Length  out  ADDR_W  count of opcodes stored, terminator excluded

## Operation
- Opcode map: 0 END, 1 '>', 2 '<', 3 '+', 4 '-', 5 '.', 6 ',', 7 '[', 8 ']'; 9-15 are invalid.
- Enter, Finish and OpSwitches each pass through a 2-flop synchronizer.
- A third flop on Enter and Finish gives a rising-edge pulse: sync2 & ~sync3.
- Opcode is sampled from synchronized OpSwitches in the edge cycle.
- States:
  - LOAD: reset state.
    - Enter edge with a valid, nonzero opcode and Full=0 -> WRITE.
    - Enter edge with opcode 0 -> TERM.
    - Enter edge with opcode 9-15: set Error, stay in LOAD, nothing written.
    - Enter edge while Full=1 is ignored.
    - Finish edge -> TERM.
  - WRITE: one cycle. PMWren=1, PMAddress=addr, PMData=opcode. Then addr and Length increment and the state returns to LOAD.
  - TERM: one cycle. PMWren=1, PMData=0, PMAddress=addr. Then -> DONE, or -> ERROR under the bracket check.
  - DONE: PMInputDone=1. All inputs ignored until reset.
  - ERROR: PMInputDone=0, Error=1. All inputs ignored until reset.
- Full = (addr == 2^ADDR_W-1). The last word is reserved for END, so a maximal program holds 2^ADDR_W-1 opcodes.
- addr never wraps.
- If Enter and Finish edges occur in the same cycle, Finish wins and the opcode is discarded.
- Reset asserted mid-load returns the block to LOAD with addr=0. Memory contents are not cleared; the next load overwrites them from 0.
- Reset values: PMAddress=0, PMData=0, PMWren=0, PMInputDone=0, Full=0, Error=0, Length=0, state LOAD, all synchronizer flops 0.

## Timing
- All outputs are registered.
- Enter rising at the input before edge K is sampled at K; the edge pulse is valid in cycle K+2; PMWren is high in cycle K+3 for exactly one cycle.
- Finish follows the same path: END is written in cycle K+3, and PMInputDone rises in cycle K+4.
- Back-to-back stores need Enter low for at least 2 cycles between presses.
- Holding a button high generates exactly one edge.
- PMAddress and PMData are stable in every cycle in which PMWren=1.

## Configuration
- PM_LOADER_BRACKET_CHECK_EN defined:
  - An up/down depth counter of ADDR_W bits increments on stored '[' and decrements on stored ']'.
  - An Enter of ']' at depth 0 is rejected: Error set, nothing written, stay in LOAD.
  - On leaving TERM, depth != 0 -> ERROR; otherwise -> DONE.
- Undefined: no depth counter. Brackets are stored unchecked, and TERM always goes to DONE.

## Test plan
- Reset low then high; press Enter with 3, 3, 5, then Finish -> writes (0,3), (1,3), (2,5), (3,0); Length=3; PMInputDone=1 from K+4 of the Finish press.
- Enter held high for 50 cycles with OpSwitches=1 -> exactly one PMWren pulse at address 0.
- OpSwitches=12 then Enter -> no PMWren, Error=1, state LOAD; a following valid '+' is written at address 0.
- Store 255 opcodes with ADDR_W=8 -> Full=1, a 256th Enter is ignored, Finish writes END at 255, PMInputDone=1.
- Enter and Finish rise in the same cycle -> a single write of END at the current address, opcode dropped.
- With PM_LOADER_BRACKET_CHECK_EN: store '[', '[', ']', then Finish -> END written, Error=1, PMInputDone=0. An Enter of ']' as the first opcode -> rejected, Error=1. Reset asserted mid-sequence -> all outputs return to their reset values immediately.
